// File: rtl/flags_unit.sv
// flags_unit: architectural NZCV flag register with a single-level saved
// copy (SPSR) used across exception entry and return.
//
// Ports
//   sys_clk       in   clock, all state updates on the rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   Flags_in      in   [3:0] new NZCV from Execute ([3]=N [2]=Z [1]=C [0]=V)
//   FlagWrite     in   [1:0] group write enables: [1]=N,Z  [0]=C,V
//   StallE        in   Execute stalled; suppresses FlagWrite only
//   FlagLoad      in   full NZCV write from FlagLoadData (wins over FlagWrite)
//   FlagLoadData  in   [3:0] value for FlagLoad
//   ExcEntry      in   one-cycle exception entry request
//   ExcReturn     in   one-cycle exception return request
//   FlagsE        out  [3:0] current NZCV (registered)
//   SavedFlags    out  [3:0] SPSR contents (registered)
//   InExc         out  1 while the FSM is in EXC (exposes FSM state)
//   ExcErr        out  registered one-cycle pulse for an illegal request
//
// Request semantics: ExcEntry/ExcReturn are single-cycle pulses with no
// handshake; each is fully resolved on the edge where it is sampled.
module flags_unit (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] Flags_in,
  input  logic [1:0] FlagWrite,
  input  logic       StallE,
  input  logic       FlagLoad,
  input  logic [3:0] FlagLoadData,
  input  logic       ExcEntry,
  input  logic       ExcReturn,
  output logic [3:0] FlagsE,
  output logic [3:0] SavedFlags,
  output logic       InExc,
  output logic       ExcErr
);

  typedef enum logic {
    RUN = 1'b0,
    EXC = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] nzcv_q, nzcv_d;
  logic [3:0] spsr_q, spsr_d;
  logic       exc_err_q, exc_err_d;

  logic [3:0] merged_flags;
  logic       req_both;
  logic       entry_ok;
  logic       return_ok;

  // State register (FSM plus datapath registers).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= RUN;
      nzcv_q    <= 4'b0000;
      spsr_q    <= 4'b0000;
      exc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nzcv_q    <= nzcv_d;
      spsr_q    <= spsr_d;
      exc_err_q <= exc_err_d;
    end
  end

  // Value NZCV would take from ordinary writes alone. Entry snapshots this
  // merged value, so a flag-setting instruction retiring in the same cycle
  // as the exception is not lost.
  always_comb begin
    merged_flags = nzcv_q;
    if (!StallE) begin
      if (FlagWrite[1]) merged_flags[3:2] = Flags_in[3:2];
      if (FlagWrite[0]) merged_flags[1:0] = Flags_in[1:0];
    end
    if (FlagLoad) merged_flags = FlagLoadData;
  end

  // Next-state logic. Simultaneous entry+return is always an error and
  // neither request takes effect.
  always_comb begin
    req_both  = ExcEntry & ExcReturn;
    entry_ok  = 1'b0;
    return_ok = 1'b0;
    exc_err_d = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      RUN: begin
        if (req_both) begin
          exc_err_d = 1'b1;
        end else if (ExcEntry) begin
          entry_ok = 1'b1;
          state_d  = EXC;
        end else if (ExcReturn) begin
          exc_err_d = 1'b1;
        end
      end
      EXC: begin
        if (req_both) begin
          exc_err_d = 1'b1;
        end else if (ExcReturn) begin
          return_ok = 1'b1;
          state_d   = RUN;
        end else if (ExcEntry) begin
          exc_err_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output / datapath logic. A valid return overrides any write this cycle.
  always_comb begin
    nzcv_d = merged_flags;
    spsr_d = spsr_q;
    if (entry_ok)  spsr_d = merged_flags;
    if (return_ok) nzcv_d = spsr_q;
  end

  assign FlagsE     = nzcv_q;
  assign SavedFlags = spsr_q;
  assign InExc      = (state_q == EXC);
  assign ExcErr     = exc_err_q;

endmodule

// File: tb/tb_flags_unit.sv
// Directed testbench for flags_unit with hand-computed expected values.
module tb_flags_unit;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] Flags_in;
  logic [1:0] FlagWrite;
  logic       StallE;
  logic       FlagLoad;
  logic [3:0] FlagLoadData;
  logic       ExcEntry;
  logic       ExcReturn;
  logic [3:0] FlagsE;
  logic [3:0] SavedFlags;
  logic       InExc;
  logic       ExcErr;

  int total_cnt;
  int bad_cnt;

  flags_unit dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .Flags_in     (Flags_in),
    .FlagWrite    (FlagWrite),
    .StallE       (StallE),
    .FlagLoad     (FlagLoad),
    .FlagLoadData (FlagLoadData),
    .ExcEntry     (ExcEntry),
    .ExcReturn    (ExcReturn),
    .FlagsE       (FlagsE),
    .SavedFlags   (SavedFlags),
    .InExc        (InExc),
    .ExcErr       (ExcErr)
  );

  // Clock / reset: 10 ns period, posedges at 5, 15, 25, ...
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic idle();
    Flags_in     = 4'b0000;
    FlagWrite    = 2'b00;
    StallE       = 1'b0;
    FlagLoad     = 1'b0;
    FlagLoadData = 4'b0000;
    ExcEntry     = 1'b0;
    ExcReturn    = 1'b0;
  endtask

  // Apply current inputs across one rising edge; return 1 ns after it.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] f, input logic [3:0] s,
                           input logic ie, input logic er);
    check({tag, ".flags"}, FlagsE, f);
    check({tag, ".saved"}, SavedFlags, s);
    check({tag, ".inexc"}, {3'b000, InExc}, {3'b000, ie});
    check({tag, ".err"}, {3'b000, ExcErr}, {3'b000, er});
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    idle();
    sys_rst_n = 1'b0;
    #3;
    check_all("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
    #9 sys_rst_n = 1'b1;   // released at t=12, between edges

    // Group writes
    Flags_in = 4'b1011; FlagWrite = 2'b10; step();
    check("grp_nz", FlagsE, 4'b1000);
    FlagWrite = 2'b01; step();
    check("grp_cv", FlagsE, 4'b1011);

    // Stall blocks FlagWrite, not FlagLoad
    StallE = 1'b1; FlagWrite = 2'b11; Flags_in = 4'b1111; step();
    check("stall_blk", FlagsE, 4'b1011);
    FlagLoad = 1'b1; FlagLoadData = 4'b0110; step();
    check("stall_load", FlagsE, 4'b0110);

    // Entry merges a same-cycle write into SPSR
    idle(); FlagLoad = 1'b1; FlagLoadData = 4'b0001; step();
    check("load_0001", FlagsE, 4'b0001);
    idle(); FlagWrite = 2'b10; Flags_in = 4'b0100; ExcEntry = 1'b1; step();
    check_all("entry", 4'b0101, 4'b0101, 1'b1, 1'b0);

    // Return overrides a same-cycle write
    idle(); FlagLoad = 1'b1; FlagLoadData = 4'b1110; step();
    check_all("exc_load", 4'b1110, 4'b0101, 1'b1, 1'b0);
    idle(); ExcReturn = 1'b1; FlagWrite = 2'b11; Flags_in = 4'b1111; step();
    check_all("return", 4'b0101, 4'b0101, 1'b0, 1'b0);

    // Return while in RUN
    idle(); ExcReturn = 1'b1; step();
    check_all("ret_run", 4'b0101, 4'b0101, 1'b0, 1'b1);
    idle(); step();
    check("ret_run_clr", {3'b000, ExcErr}, 4'b0000);
    idle(); ExcReturn = 1'b1; FlagWrite = 2'b01; Flags_in = 4'b0010; step();
    check_all("ret_run_wr", 4'b0110, 4'b0101, 1'b0, 1'b1);

    // Nested entry
    idle(); ExcEntry = 1'b1; step();
    check_all("entry2", 4'b0110, 4'b0110, 1'b1, 1'b0);
    idle(); ExcEntry = 1'b1; FlagLoad = 1'b1; FlagLoadData = 4'b1001; step();
    check_all("nested", 4'b1001, 4'b0110, 1'b1, 1'b1);
    idle(); step();
    check("nested_clr", {3'b000, ExcErr}, 4'b0000);

    // Both requests in EXC: writes still apply, state and SPSR hold
    idle(); ExcEntry = 1'b1; ExcReturn = 1'b1; FlagWrite = 2'b10; Flags_in = 4'b0100; step();
    check_all("both_exc", 4'b0101, 4'b0110, 1'b1, 1'b1);
    idle(); step();
    check("both_exc_clr", {3'b000, ExcErr}, 4'b0000);

    // Return is not blocked by StallE
    idle(); StallE = 1'b1; ExcReturn = 1'b1; FlagWrite = 2'b11; step();
    check_all("ret_stall", 4'b0110, 4'b0110, 1'b0, 1'b0);

    // Both requests in RUN
    idle(); ExcEntry = 1'b1; ExcReturn = 1'b1; step();
    check_all("both_run", 4'b0110, 4'b0110, 1'b0, 1'b1);

    // Asynchronous reset mid-exception
    idle(); FlagLoad = 1'b1; FlagLoadData = 4'b1010; ExcEntry = 1'b1; step();
    check_all("entry3", 4'b1010, 4'b1010, 1'b1, 1'b0);
    idle();
    #2 sys_rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    FlagWrite = 2'b11; Flags_in = 4'b1100; step();
    check_all("post_rst", 4'b1100, 4'b0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/flags_unit.md
FLAGS_UNIT -- requirements
Module: flags_unit

Interface
REQ-001 The block SHALL have the port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port Flags_in, input, 4 bits: new NZCV values from Execute-stage condition logic ([3]=N, [2]=Z, [1]=C, [0]=V).
REQ-004 The block SHALL have the port FlagWrite, input, 2 bits: condition-gated write enables; [1] selects N,Z and [0] selects C,V.
REQ-005 The block SHALL have the port StallE, input, 1 bit: Execute stage stalled; blocks flag writes.
REQ-006 The block SHALL have the port FlagLoad, input, 1 bit: direct full write of NZCV (MSR-style).
REQ-007 The block SHALL have the port FlagLoadData, input, 4 bits: value written when FlagLoad=1.
REQ-008 The block SHALL have the port ExcEntry, input, 1 bit: one-cycle pulse requesting exception entry.
REQ-009 The block SHALL have the port ExcReturn, input, 1 bit: one-cycle pulse requesting exception return.
REQ-010 The block SHALL have the port FlagsE, output, 4 bits: current architectural NZCV, fed to Execute condition check.
REQ-011 The block SHALL have the port SavedFlags, output, 4 bits: contents of the saved-flags (SPSR) register.
REQ-012 The block SHALL have the port InExc, output, 1 bit: 1 while in state EXC.
REQ-013 The block SHALL have the port ExcErr, output, 1 bit: one-cycle error pulse for an illegal entry or return.

Function
REQ-014 NZCV and SPSR SHALL be 4-bit registers, and FlagsE and SavedFlags SHALL be their direct register outputs with no combinational path from inputs.
REQ-015 A normal write with StallE=0 SHALL update NZCV[3:2] from Flags_in[3:2] when FlagWrite[1]=1, and NZCV[1:0] from Flags_in[1:0] when FlagWrite[0]=1; the two groups are independent.
REQ-016 While StallE=1, FlagWrite SHALL be ignored; FlagLoad, ExcEntry and ExcReturn are not blocked by StallE.
REQ-017 FlagLoad=1 SHALL write all four bits from FlagLoadData and take priority over FlagWrite in the same cycle.
REQ-018 The FSM SHALL have two states: RUN (reset) and EXC.
REQ-019 In RUN, ExcEntry=1 SHALL set SPSR to the NZCV value that would be written this cycle (after any FlagLoad or FlagWrite merge) and move the FSM to EXC.
REQ-020 In EXC, ExcReturn=1 SHALL copy SPSR to NZCV and move the FSM to RUN; the restore overrides any FlagLoad or FlagWrite in that cycle.
REQ-021 ExcEntry in EXC (nested entry) SHALL leave SPSR unchanged and the FSM in EXC, and SHALL pulse ExcErr=1 in the next cycle.
REQ-022 ExcReturn in RUN SHALL leave NZCV unchanged except for normal writes, and SHALL pulse ExcErr=1 in the next cycle.
REQ-023 ExcEntry and ExcReturn asserted together SHALL be treated as an error: no state change, no SPSR or NZCV change from either request, ExcErr pulse; normal and load writes still apply.
REQ-024 InExc SHALL equal (state==EXC) and change one cycle after the accepted request.
REQ-025 ExcErr SHALL be registered, high for exactly one cycle per erroneous request, and low otherwise.
REQ-026 Latency SHALL be one cycle: any write is visible on FlagsE in the cycle after the clock edge that performed it.

Reset
REQ-027 While sys_rst_n=0, asynchronously: NZCV=4'b0000, SPSR=4'b0000, state=RUN, FlagsE=0, SavedFlags=0, InExc=0, ExcErr=0.
REQ-028 Reset asserted mid-exception SHALL discard SPSR and return to RUN; the first edge after deassertion SHALL process inputs normally.

Verification
REQ-029 Group write: NZCV=0000, Flags_in=1011, FlagWrite=10 -> FlagsE=1000 next cycle; then FlagWrite=01 -> 1011.
REQ-030 Stall and load: StallE=1, FlagWrite=11, Flags_in=1111 -> FlagsE unchanged; FlagLoad=1 with FlagLoadData=0110 in the same cycle -> FlagsE=0110.
REQ-031 Entry with write: NZCV=0001, FlagWrite=10, Flags_in=0100, ExcEntry=1 -> SavedFlags=0101, FlagsE=0101, InExc=1.
REQ-032 Return over write: in EXC with SPSR=0101, NZCV=1110, ExcReturn=1, FlagWrite=11, Flags_in=1111 -> FlagsE=0101, InExc=0.
REQ-033 Errors: ExcReturn in RUN -> ExcErr pulses for one cycle and FlagsE is unchanged; a second ExcEntry in EXC -> ExcErr pulses and SavedFlags keeps its value; simultaneous ExcEntry and ExcReturn -> ExcErr pulses and the state is unchanged.
REQ-034 Asynchronous reset asserted between clock edges while InExc=1, SPSR=1010 -> all outputs 0 immediately, with no clock edge needed.
